// File: rtl/rv32_imem_reader.sv
// rv32_imem_reader: streams a run of imem words out on a valid/ready channel.
// Sync-read RAM port, 2-entry output FIFO, credit-based read issue.
module rv32_imem_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              rv32_io_clk,
  input  logic              rv32_io_rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_last_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W:0]     r_rd_rem;
  logic                r_busy;
  logic                r_done;
  logic                r_inflight;
  logic [ADDR_W-1:0]   r_inf_addr;
  logic                r_inf_last;

  logic [DATA_W-1:0]   r_buf_data [2];
  logic [ADDR_W-1:0]   r_buf_addr [2];
  logic                r_buf_last [2];
  logic                r_head;
  logic                r_tail;
  logic [1:0]          r_occ;

  logic                w_pop;
  logic                w_push;
  logic                w_issue;
  logic [2:0]          w_used;
  logic [2:0]          w_limit;
  logic                w_rem_one;

  // Credit: a read may issue only if its word is sure to find a free slot.
  assign w_pop     = out_valid_o & out_ready_i;
  assign w_push    = r_inflight;
  assign w_used    = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_limit   = 3'd2 + {2'b00, w_pop};
  assign w_issue   = (r_state == S_READ) && (w_used < w_limit);
  assign w_rem_one = (r_rd_rem == {{ADDR_W{1'b0}}, 1'b1});

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign mem_rd_en_o = w_issue;
  assign mem_addr_o  = r_rd_addr;
  assign out_valid_o = (r_occ != 2'd0);
  assign out_data_o  = r_buf_data[r_head];
  assign out_addr_o  = r_buf_addr[r_head];
  assign out_last_o  = r_buf_last[r_head];

  // Run control: capture the request, issue reads, end on the last handshake.
  always_ff @(posedge rv32_io_clk) begin
    if (rv32_io_rst) begin
      r_state    <= S_IDLE;
      r_rd_addr  <= '0;
      r_rd_rem   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_inflight <= 1'b0;
      r_inf_addr <= '0;
      r_inf_last <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inf_addr <= r_rd_addr;
        r_inf_last <= w_rem_one;
        r_rd_addr  <= r_rd_addr + 1'b1;
        r_rd_rem   <= r_rd_rem - 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_rd_addr <= base_addr_i;
            r_rd_rem  <= count_i;
            r_busy    <= 1'b1;
            if (count_i == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (w_issue && w_rem_one) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_pop && out_last_o) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output FIFO: push returning words, pop on handshake.
  always_ff @(posedge rv32_io_clk) begin
    if (rv32_io_rst) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_occ  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_addr[i] <= '0;
        r_buf_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_buf_data[r_tail] <= mem_rdata_i;
        r_buf_addr[r_tail] <= r_inf_addr;
        r_buf_last[r_tail] <= r_inf_last;
        r_tail             <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_rv32_imem_reader.sv
// tb_rv32_imem_reader: directed and random runs against a
// list-of-expected-words model of the imem readback stream.
module tb_rv32_imem_reader;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_i = '0;
  logic [AW:0]   count_i = '0;
  logic          busy, done;
  logic          rd_en;
  logic [AW-1:0] maddr;
  logic [DW-1:0] rdata = '0;
  logic          valid;
  logic          ready = 1'b1;
  logic [DW-1:0] odata;
  logic [AW-1:0] oaddr;
  logic          olast;

  rv32_imem_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .rv32_io_clk (clk),
    .rv32_io_rst (rst),
    .start_i     (start),
    .base_addr_i (base_i),
    .count_i     (count_i),
    .busy_o      (busy),
    .done_o      (done),
    .mem_rd_en_o (rd_en),
    .mem_addr_o  (maddr),
    .mem_rdata_i (rdata),
    .out_valid_o (valid),
    .out_ready_i (ready),
    .out_data_o  (odata),
    .out_addr_o  (oaddr),
    .out_last_o  (olast)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem [N];
  always @(posedge clk) if (rd_en) rdata <= mem[maddr];

  typedef struct packed {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int hs_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_v = -1;
  int outst = 0;
  bit stall = 0;
  bit prev_v = 0;
  logic [AW+DW+1:0] held;

  always @(negedge clk) begin
    if (rst) begin
      outst  = 0;
      stall  = 0;
      prev_v = 0;
    end else begin
      check("outstanding_le2", outst <= 2, 1);
      if (stall)
        check("stall_hold", {valid, oaddr, odata, olast}, held);
      if (valid && !prev_v) first_v = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rd_en) rd_cnt++;
      if (valid && ready) begin
        exp_t e;
        hs_cnt++;
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_addr", oaddr, e.a);
          check("out_data", odata, e.d);
          check("out_last", olast, e.l);
        end
      end
      outst = outst + int'(rd_en) - int'(valid && ready);
      stall  = valid && !ready;
      prev_v = valid;
      held   = {1'b1, oaddr, odata, olast};
    end
  end

  task automatic fill(input int base, input int cnt);
    exp_t e;
    for (int i = 0; i < cnt; i++) begin
      e.a = AW'((base + i) % N);
      e.d = mem[e.a];
      e.l = (i == cnt - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic go(input int base, input int cnt);
    @(posedge clk); #1;
    start   = 1'b1;
    base_i  = AW'(base);
    count_i = (AW+1)'(cnt);
    ready   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    base_i  = AW'($urandom);
    count_i = (AW+1)'($urandom);
  endtask

  task automatic run(input int base, input int cnt, input int rmode,
                     input bit mid);
    int t0, g, h0, r0, d0;
    fill(base, cnt);
    h0 = hs_cnt;
    r0 = rd_cnt;
    d0 = done_cnt;
    go(base, cnt);
    t0 = cyc;
    check("busy_rise", busy, 1);
    g = 0;
    while (done_cnt == d0 && g < 300) begin
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = (g % 4 == 0) || (g % 4 == 3);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      start = mid && (g == 3);
      @(posedge clk); #1;
      g++;
    end
    start = 1'b0;
    ready = 1'b1;
    check("run_timeout", g < 300, 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    check("word_count", hs_cnt - h0, cnt);
    check("read_count", rd_cnt - r0, cnt);
    check("queue_empty", exp_q.size(), 0);
    check("busy_fall", busy, 0);
    if (rmode == 0)
      check("done_cycle", done_cyc, (cnt == 0) ? t0 : t0 + cnt + 2);
    if (rmode == 0 && cnt > 0)
      check("first_valid", first_v, t0 + 2);
    exp_q.delete();
  endtask

  task automatic outs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_maddr"}, maddr, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_data"}, odata, 0);
    check({tag, "_addr"}, oaddr, 0);
    check({tag, "_last"}, olast, 0);
  endtask

  initial begin
    int g, h0, d0;
    for (int i = 0; i < N; i++) mem[i] = 32'h13 + i;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run(4, 8, 0, 0);
    run(4, 8, 1, 0);
    run(14, 4, 0, 0);
    run(0, 0, 0, 0);
    run(2, 6, 0, 1);
    run(5, 16, 0, 0);

    fill(4, 8);
    h0 = hs_cnt;
    d0 = done_cnt;
    go(4, 8);
    g = 0;
    while (hs_cnt - h0 < 3 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("rst_wait", g < 50, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outs_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check("no_done_on_abort", done_cnt - d0, 0);
    run(0, 1, 0, 0);

    for (int k = 0; k < 14; k++) begin
      for (int i = 0; i < N; i++) mem[i] = $urandom;
      run($urandom_range(0, N - 1), $urandom_range(0, N),
          $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_imem_reader.md
# rv32_imem_reader

Readback engine for the pito instruction memory: the read-side counterpart of the program-load path that writes instructions into imem through a write enable, an address and a data word. On a start command it reads a run of consecutive imem words through a synchronous read port with 1-cycle latency. It streams each word with its address on a valid/ready output channel, so a bench or debug host can dump and compare loaded program contents. A 2-entry output buffer absorbs the RAM latency and sustains 1 word/cycle under no backpressure.

## Interface
- ADDR_W, 12, imem word-address width; memory depth = 2^ADDR_W words
- DATA_W, 32, instruction word width
- rv32_io_clk  in  1  clock, all logic on rising edge
- rv32_io_rst  in  1  reset, synchronous, active-high
- start_i  in  1  start request, sampled only in IDLE
- base_addr_i  in  ADDR_W  first word address, captured with start_i
- count_i  in  ADDR_W+1  number of words to read, captured with start_i; 0 is legal
- busy_o  out  1  high while a run is in progress
- done_o  out  1  1-cycle pulse at end of run
- mem_rd_en_o  out  1  imem read strobe
- mem_addr_o  out  ADDR_W  imem read address
- mem_rdata_i  in  DATA_W  imem read data, valid the cycle after mem_rd_en_o
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  consumer ready
- out_data_o  out  DATA_W  instruction word
- out_addr_o  out  ADDR_W  imem address of out_data_o
- out_last_o  out  1  marks the final word of the run; qualified by out_valid_o

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: on start_i, capture base_addr_i into rd_addr and count_i into rd_remaining.
  - count_i == 0: go to DONE.
  - Otherwise go to READ.
- READ: issue a read (mem_rd_en_o=1, mem_addr_o=rd_addr) when occ + inflight − pop < 2.
  - occ: buffer occupancy, 0..2.
  - inflight: 1 if a read was issued last cycle.
  - pop: out_valid_o & out_ready_i.
  - Each issue increments rd_addr modulo 2^ADDR_W (wraps from all-ones to 0) and decrements rd_remaining.
  - When rd_remaining reaches 0, go to DRAIN.
- DRAIN: no reads. When occ == 0, inflight == 0 and the last word has handshaken, go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Buffer write: each returning word is pushed the cycle after its read, with its address and a last flag. The last flag is set when the word was issued with rd_remaining == 1.
- Buffer order: words leave in FIFO order. The buffer never overflows, because the credit rule above guarantees it.
- Output channel: out_valid_o = (occ != 0). out_data_o, out_addr_o and out_last_o show the head entry and stay stable while out_valid_o & !out_ready_i.
- start_i while not in IDLE is ignored. base_addr_i and count_i are not re-sampled.
- count_i == 2^ADDR_W reads the whole memory, wrapping back to base_addr_i's predecessor.

## Timing
- Reset values of outputs: busy_o=0, done_o=0, mem_rd_en_o=0, mem_addr_o=0, out_valid_o=0, out_data_o=0, out_addr_o=0, out_last_o=0.
- Reset clears internal state: FSM in IDLE, occ=0, inflight=0.
- Reset mid-run aborts immediately, with no done_o pulse. Read data returning the cycle after reset is discarded.
- Latency, with start sampled at edge T:
  - busy_o high from T+1 until the DONE cycle inclusive.
  - First mem_rd_en_o in cycle T+1.
  - First word pushed at edge T+2; out_valid_o high in cycle T+2+1 = T+3.
- Throughput: with out_ready_i held high, one mem_rd_en_o per cycle and one output word per cycle, N words in N+2 cycles after start.
  - done_o is in the cycle after the last handshake.
- mem_rd_en_o depends combinationally on out_ready_i, through the pop term only.
- Backpressure: with out_ready_i low, at most 2 reads are outstanding (occ + inflight ≤ 2), then reads stall. Reads resume in the same cycle out_ready_i rises.
- count 0: done_o pulses at T+1 (the cycle after the start edge). No mem_rd_en_o and no out_valid_o.

## Test plan
- Reset and idle:
  - Assert rst for 2 cycles mid-run (count=8, after 3 words) → all outputs 0 next cycle.
  - No done_o pulse.
  - A new start with base=0, count=1 returns only imem[0].
- Streaming:
  - Preload imem[0..15] = 0x00000013+i; start base=4, count=8, ready=1.
  - Expect out_addr 4..11 with data 0x17..0x1E on consecutive cycles, first valid at T+3.
  - out_last only on addr 11; done_o one cycle later.
- Backpressure:
  - Same run with ready toggled 1,0,0,1 repeating → identical word sequence.
  - Never more than 2 reads outstanding; data held stable while stalled.
- Wrap-around: ADDR_W=4, start base=14, count=4 → addresses 14,15,0,1 in order; out_last on 1.
- Zero count and ignored start:
  - count=0 → done_o at T+1, no reads.
  - start_i pulsed during a busy run → run unchanged, no extra words.
- Full memory: ADDR_W=4, count=16, base=5 → 16 words, addr 5..15,0..4; done_o once.
